// File: rtl/comb_bist_pkg.sv
// Shared definitions for the combinational-circuit self-test engine.
// Holds the run-state encoding and a width helper for the settle counter.
// Ports: none (package).
package comb_bist_pkg;

  // Run states; values fix the encoding seen on any debug tap.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Ceiling log2, at least 1 bit, for sizing small counters.
  function automatic int ctr_width(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comb_bist_settle_timer.sv
// Settle interval timer: counts cycles while enabled, flags the last one.
// Ports: clk, rst (sync, active-high), clear, enable in; expired out, which is
// high during the enabled cycle in which the count equals SETTLE-1.
module comb_bist_settle_timer
  import comb_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ctr_width(SETTLE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/comb_bist_checker.sv
// Self-test engine: walks all 2^NIN input vectors in ascending order, holds
// each for SETTLE cycles, samples dut_out and checks it against EXPECTED.
// Ports: clk, rst, start in; dut_in out / dut_out in (circuit under test);
// busy, done, pass, err_count, first_fail, first_fail_valid out (all registered).
module comb_bist_checker
  import comb_bist_pkg::*;
#(
  parameter int                     NIN      = 3,
  parameter logic [(1<<NIN)-1:0]    EXPECTED = 8'b0100_0000,
  parameter int                     SETTLE   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [NIN-1:0] dut_in,
  input  logic           dut_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_count,
  output logic [NIN-1:0] first_fail,
  output logic           first_fail_valid
);

  localparam logic [NIN-1:0] LAST_VEC = '1;
  localparam logic [NIN:0]   ERR_MAX  = {1'b1, {NIN{1'b0}}};

  state_t         state, state_n;
  logic [NIN-1:0] dut_in_n;
  logic           busy_n, done_n, pass_n;
  logic [NIN:0]   err_n;
  logic [NIN-1:0] ff_n;
  logic           ffv_n;
  logic           mismatch;
  logic           expired;

  // Timer runs only in SETTLE and is held at zero everywhere else, so it
  // restarts for every vector without an explicit clear pulse.
  comb_bist_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_SETTLE),
    .enable  (state == ST_SETTLE),
    .expired (expired)
  );

  // Case inequality so an undriven or X output is reported as a failure.
  assign mismatch = (dut_out !== EXPECTED[dut_in]);

  always_comb begin
    state_n  = state;
    dut_in_n = dut_in;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_count;
    ff_n     = first_fail;
    ffv_n    = first_fail_valid;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n  = ST_SETTLE;
          dut_in_n = '0;
          busy_n   = 1'b1;
          done_n   = 1'b0;
          pass_n   = 1'b0;
          err_n    = '0;
          ff_n     = '0;
          ffv_n    = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (expired) state_n = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_n = err_count + 1'b1;
          if (!first_fail_valid) begin
            ff_n  = dut_in;
            ffv_n = 1'b1;
          end
        end
        if (dut_in == LAST_VEC) begin
          // pass reflects the count including this final comparison.
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n  = ST_SETTLE;
          dut_in_n = dut_in + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_n;
      dut_in           <= dut_in_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      err_count        <= err_n;
      first_fail       <= ff_n;
      first_fail_valid <= ffv_n;
    end
  end

endmodule

// File: tb/tb_comb_bist_checker.sv
// Directed bench for comb_bist_checker: default instance (NIN=3, SETTLE=2)
// and a small instance (NIN=2, SETTLE=1) driving modelled lab circuits.
module tb_comb_bist_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         mode = 0;   // 0 golden, 1 stuck-at-0, 2 inverted
  int         mode2 = 0;  // 0 golden, 1 stuck-at-0

  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, ffv;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  logic [1:0] dut_in2;
  logic       dut_out2;
  logic       busy2, done2, pass2, ffv2;
  logic [2:0] err_count2;
  logic [1:0] first_fail2;

  int compared = 0;
  int mismatched = 0;
  int n;

  always #5 clk = ~clk;

  // Lab circuit models: golden is out = a & b & ~c.
  assign dut_out  = (mode == 0) ? (dut_in == 3'b110) :
                    (mode == 1) ? 1'b0 : (dut_in != 3'b110);
  assign dut_out2 = (mode2 == 0) ? (dut_in2 == 2'b11) : 1'b0;

  comb_bist_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .first_fail_valid(ffv)
  );

  comb_bist_checker #(.NIN(2), .EXPECTED(4'b1000), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_fail(first_fail2), .first_fail_valid(ffv2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Counts edges after the start edge until done; optionally checks that
  // vector k/3 is on dut_in during the k-th cycle of the run.
  task automatic wait_done(input bit chk_vec, output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      if (chk_vec && cnt < 24) check("vec_hold", dut_in, cnt / 3);
      tick();
      cnt++;
    end
  endtask

  task automatic wait_done2(output int cnt);
    cnt = 0;
    while (done2 !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ff", first_fail, 0);
    check("rst_ffv", ffv, 0);
    check("rst_din", dut_in, 0);
    check("rst_done2", done2, 0);
    rst = 1'b0;
    tick();
    tick();

    // Golden circuit
    mode = 0;
    start_run();
    check("gold_busy", busy, 1);
    wait_done(1'b1, n);
    check("gold_latency", n, 24);
    check("gold_busy_end", busy, 0);
    check("gold_pass", pass, 1);
    check("gold_err", err_count, 0);
    check("gold_ffv", ffv, 0);
    check("gold_din_hold", dut_in, 7);
    tick();
    tick();
    check("gold_done_held", done, 1);

    // Stuck-at-0 circuit
    mode = 1;
    start_run();
    check("sa0_done_clr", done, 0);
    wait_done(1'b0, n);
    check("sa0_latency", n, 24);
    check("sa0_pass", pass, 0);
    check("sa0_err", err_count, 1);
    check("sa0_ff", first_fail, 3'b110);
    check("sa0_ffv", ffv, 1);

    // Restart from DONE with golden circuit: results clear on the start edge
    mode = 0;
    start_run();
    check("rs_err_clr", err_count, 0);
    check("rs_ffv_clr", ffv, 0);
    check("rs_ff_clr", first_fail, 0);
    check("rs_busy", busy, 1);
    check("rs_done", done, 0);
    wait_done(1'b0, n);
    check("rs_latency", n, 24);
    check("rs_pass", pass, 1);

    // Inverted circuit
    mode = 2;
    start_run();
    wait_done(1'b0, n);
    check("inv_err", err_count, 8);
    check("inv_ff", first_fail, 0);
    check("inv_ffv", ffv, 1);
    check("inv_pass", pass, 0);

    // start held through a whole golden run: no restart while busy
    mode = 0;
    start = 1'b1;
    tick();
    wait_done(1'b1, n);
    start = 1'b0;
    check("hold_latency", n, 24);
    check("hold_pass", pass, 1);
    check("hold_err", err_count, 0);
    tick();
    check("hold_done_after", done, 1);

    // rst during SETTLE of vector 5, with start also high
    mode = 2;
    start_run();
    for (int i = 0; i < 15; i++) tick();
    check("mid_din5", dut_in, 5);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("mid_rst_din", dut_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_ffv", ffv, 0);
    check("mid_rst_pass", pass, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("mid_idle_busy", busy, 0);
    start_run();
    wait_done(1'b0, n);
    check("mid_rerun_latency", n, 24);
    check("mid_rerun_err", err_count, 8);
    check("mid_rerun_ff", first_fail, 0);

    // Small instance: NIN=2, SETTLE=1, stuck-at-0 then golden restart
    mode2 = 1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done2(n);
    check("s2_sa0_latency", n, 8);
    check("s2_sa0_err", err_count2, 1);
    check("s2_sa0_ff", first_fail2, 3);
    check("s2_sa0_ffv", ffv2, 1);
    check("s2_sa0_pass", pass2, 0);
    mode2 = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("s2_rs_err_clr", err_count2, 0);
    check("s2_rs_busy", busy2, 1);
    wait_done2(n);
    check("s2_gold_latency", n, 8);
    check("s2_gold_pass", pass2, 1);
    check("s2_gold_err", err_count2, 0);
    check("s2_gold_din", dut_in2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
